// File: rtl/pocket_lab_pkg.sv
// Shared constants for the pocket lab DAC/ADC channels: frame flag bytes,
// readout FSM state encoding (8-bit codes, as in the DAC FSM), length width.
package pocket_lab_pkg;

    localparam logic [7:0] DAC_FLAG_BYTE = 8'h5A;
    localparam logic [7:0] ADC_FLAG_BYTE = 8'hA5;

    localparam int LEN_W = 16;

    localparam logic [7:0] ST_IDLE      = 8'h00;
    localparam logic [7:0] ST_RX_ADDR   = 8'h01;
    localparam logic [7:0] ST_RX_LEN_LB = 8'h02;
    localparam logic [7:0] ST_RX_LEN_HB = 8'h03;
    localparam logic [7:0] ST_FETCH     = 8'h04;
    localparam logic [7:0] ST_SEND      = 8'h05;
    localparam logic [7:0] ST_CSUM      = 8'h06;

    // Assemble a 16-bit length from its two frame bytes.
    function automatic logic [LEN_W-1:0] len_join(
        input logic [7:0] hb,
        input logic [7:0] lb
    );
        return {hb, lb};
    endfunction

endpackage

// File: rtl/adc_readout_capture_ram.sv
// capture_ram: simple dual-port byte buffer, one synchronous write port and
// one registered read port (1-cycle latency, read-before-write on collision).
// Ports: clk; we/wr_addr/wr_data write port; rd_en/rd_addr/rd_data read port.
module capture_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads sample the array before this edge's write lands, so a
    // same-address collision returns the old byte.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_readout.sv
// adc_readout: ADC sample capture into a byte buffer and SPI read-back path.
// Read requests arrive as A5,addr_hi,len_lb,len_hb on the rx byte socket;
// the requested bytes leave on the tx socket via valid/ready.
// Ports: clk, reset (async, active high); capture_start, adc_valid,
//   adc_data, capture_done (capture side); rxd_out, rxd_flag, spi_cs
//   (rx socket); txd_data, txd_valid, txd_ready (tx socket); busy.
// Build option: READOUT_CHECKSUM_EN appends a mod-256 sum byte per frame.
module adc_readout
    import pocket_lab_pkg::*;
#(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] FLAG_BYTE = ADC_FLAG_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture_start,
    input  logic       adc_valid,
    input  logic [7:0] adc_data,
    output logic       capture_done,
    input  logic [7:0] rxd_out,
    input  logic       rxd_flag,
    input  logic       spi_cs,
    output logic [7:0] txd_data,
    output logic       txd_valid,
    input  logic       txd_ready,
    output logic       busy
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

`ifdef READOUT_CHECKSUM_EN
    localparam logic [7:0] ST_AFTER_DATA = ST_CSUM;
`else
    localparam logic [7:0] ST_AFTER_DATA = ST_IDLE;
`endif

    logic              capturing;
    logic [ADDR_W-1:0] wr_ptr;
    logic              cap_we;

    logic [7:0]        state;
    logic [7:0]        state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LEN_W-1:0]  cnt;
    logic [7:0]        ram_q;
    logic              rd_en;
    logic              abort;
    logic              xfer;
    logic              last;

`ifdef READOUT_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // A restart pulse wins over a same-cycle strobe.
    assign cap_we = capturing & adc_valid & ~capture_start;

    assign rd_en = (state == ST_FETCH);
    assign abort = spi_cs & (state != ST_IDLE);
    assign xfer  = txd_valid & txd_ready;
    assign last  = (cnt == LEN_W'(1));

    capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (cap_we),
        .wr_addr (wr_ptr),
        .wr_data (adc_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capturing    <= 1'b0;
            wr_ptr       <= '0;
            capture_done <= 1'b0;
        end else if (capture_start) begin
            capturing    <= 1'b1;
            wr_ptr       <= '0;
            capture_done <= 1'b0;
        end else if (cap_we) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == PTR_LAST) begin
                capturing    <= 1'b0;
                capture_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rxd_flag && rxd_out == FLAG_BYTE) begin
                        state_nxt = ST_RX_ADDR;
                    end
                end
                ST_RX_ADDR: begin
                    if (rxd_flag) begin
                        state_nxt = ST_RX_LEN_LB;
                    end
                end
                ST_RX_LEN_LB: begin
                    if (rxd_flag) begin
                        state_nxt = ST_RX_LEN_HB;
                    end
                end
                ST_RX_LEN_HB: begin
                    if (rxd_flag) begin
                        if (len_join(rxd_out, cnt[7:0]) == '0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_nxt = ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        state_nxt = last ? ST_AFTER_DATA : ST_FETCH;
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        state_nxt = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // The RAM output register only reloads in FETCH, so txd_data stays
    // stable for as long as SEND waits on txd_ready.
    always_comb begin
        busy      = (state != ST_IDLE);
        txd_valid = 1'b0;
        txd_data  = '0;
        case (state)
            ST_SEND: begin
                txd_valid = 1'b1;
                txd_data  = ram_q;
            end
`ifdef READOUT_CHECKSUM_EN
            ST_CSUM: begin
                txd_valid = 1'b1;
                txd_data  = sum;
            end
`endif
            default: begin
                txd_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_RX_ADDR: begin
                    if (rxd_flag) begin
                        rd_ptr <= ADDR_W'({rxd_out, 8'h00});
                    end
                end
                ST_RX_LEN_LB: begin
                    if (rxd_flag) begin
                        cnt[7:0] <= rxd_out;
                    end
                end
                ST_RX_LEN_HB: begin
                    if (rxd_flag) begin
                        cnt[15:8] <= rxd_out;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                        cnt    <= cnt - LEN_W'(1);
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

`ifdef READOUT_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (state == ST_RX_LEN_HB && rxd_flag) begin
            sum <= '0;
        end else if (state == ST_SEND && xfer && !abort) begin
            sum <= sum + ram_q;
        end
    end
`endif

endmodule
